// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter granting one of four requesters access to a shared ALU.
// A grant is held until done or until it has been held TIMEOUT cycles.
module alu_rr_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_vld,
   output logic       busy,
   output logic       timeout_err
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_BUSY = 1'b1;
   localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

   logic       r_state;
   logic [1:0] r_ptr;
   logic [1:0] r_idx;
   logic [7:0] r_cnt;
   logic       r_terr;

   logic [1:0] w_winner;
   logic [1:0] w_cand;
   logic       w_any;

   // Scan from lowest to highest priority so the last hit is the winner.
   always_comb begin
      w_any    = |req;
      w_winner = r_ptr;
      w_cand   = r_ptr;
      for (int k = 4; k >= 1; k--) begin
         w_cand = r_ptr + 2'(k);
         if (req[w_cand]) begin
            w_winner = w_cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ptr   <= 2'd3;
         r_idx   <= 2'd0;
         r_cnt   <= 8'd0;
         r_terr  <= 1'b0;
      end else begin
         r_terr <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_state <= ST_BUSY;
                  r_idx   <= w_winner;
                  r_ptr   <= w_winner;
                  r_cnt   <= 8'd0;
               end
            end
            ST_BUSY: begin
               if (done) begin
                  r_state <= ST_IDLE;
               end else if (r_cnt == CNT_MAX) begin
                  r_state <= ST_IDLE;
                  r_terr  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign gnt_vld     = (r_state == ST_BUSY);
   assign busy        = gnt_vld;
   assign gnt_idx     = r_idx;
   assign gnt         = gnt_vld ? (4'b0001 << r_idx) : 4'b0000;
   assign timeout_err = r_terr;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed scenarios plus random traffic against a
// behavioural model of the round-robin / timeout rules.
module tb_alu_rr_arbiter;

   localparam int unsigned TO = 15;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_vld;
   logic       busy;
   logic       timeout_err;

   int n_tests;
   int n_fail;

   // Behavioural model state
   bit m_vld;
   int m_idx;
   int m_last;
   int m_age;
   bit m_terr;

   alu_rr_arbiter #(.TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .gnt         (gnt),
      .gnt_idx     (gnt_idx),
      .gnt_vld     (gnt_vld),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] exp_gnt();
      logic [3:0] g;
      g = 4'b0000;
      if (m_vld) g[m_idx] = 1'b1;
      return g;
   endfunction

   task automatic model_reset();
      m_vld  = 0;
      m_idx  = 0;
      m_last = 3;
      m_age  = 0;
      m_terr = 0;
   endtask

   // Advance one clock edge, update the model from the inputs seen at that edge.
   task automatic step();
      bit found;
      @(posedge clk);
      m_terr = 0;
      if (!m_vld) begin
         if (req != 4'b0000) begin
            found = 0;
            for (int k = 1; k <= 4; k++) begin
               if (!found && req[(m_last + k) % 4]) begin
                  m_idx = (m_last + k) % 4;
                  found = 1;
               end
            end
            m_last = m_idx;
            m_vld  = 1;
            m_age  = 0;
         end
      end else if (done) begin
         m_vld = 0;
      end else if (m_age + 1 >= TO) begin
         m_vld  = 0;
         m_terr = 1;
      end else begin
         m_age++;
      end
      #1;
   endtask

   task automatic test_reset();
      n_tests++;
      if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs gnt=%b vld=%b busy=%b terr=%b, required 0000/0/0/0",
                  gnt, gnt_vld, busy, timeout_err);
      end
      n_tests++;
      if (gnt_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_idx gnt_idx=%0d, required 0", gnt_idx);
      end
   endtask

   task automatic test_rr_order();
      int exp_order[5] = '{0, 1, 2, 3, 0};
      req  = 4'b1111;
      done = 1'b0;
      for (int g = 0; g < 5; g++) begin
         step();
         n_tests++;
         if (gnt_vld !== 1'b1 || gnt_idx !== 2'(exp_order[g]) || gnt !== exp_gnt()) begin
            n_fail++;
            $display("FAIL rr_order[%0d] vld=%b idx=%0d gnt=%b, required 1/%0d/%b",
                     g, gnt_vld, gnt_idx, gnt, exp_order[g], exp_gnt());
         end
         step();
         done = 1'b1;
         step();
         done = 1'b0;
         n_tests++;
         if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_idx !== 2'(exp_order[g])) begin
            n_fail++;
            $display("FAIL rr_dead_cycle[%0d] gnt=%b vld=%b idx=%0d, required 0000/0/%0d",
                     g, gnt, gnt_vld, gnt_idx, exp_order[g]);
         end
      end
   endtask

   task automatic test_single_hold();
      req = 4'b0100;
      step();
      n_tests++;
      if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin
         n_fail++;
         $display("FAIL single_grant gnt=%b idx=%0d, required 0100/2", gnt, gnt_idx);
      end
      req = 4'b0000;
      for (int k = 1; k < int'(TO); k++) begin
         step();
         n_tests++;
         if (gnt !== 4'b0100 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_cycle[%0d] gnt=%b terr=%b, required 0100/0", k, gnt, timeout_err);
         end
      end
      step();
      n_tests++;
      if (gnt !== 4'b0000 || timeout_err !== 1'b1 || gnt_idx !== 2'd2) begin
         n_fail++;
         $display("FAIL hold_timeout gnt=%b terr=%b idx=%0d, required 0000/1/2",
                  gnt, timeout_err, gnt_idx);
      end
      step();
      n_tests++;
      if (timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL terr_pulse_width terr=%b, required 0", timeout_err);
      end
   endtask

   task automatic test_timeout();
      req = 4'b0010;
      step();
      n_tests++;
      if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
         n_fail++;
         $display("FAIL to_grant1 gnt=%b idx=%0d, required 0010/1", gnt, gnt_idx);
      end
      req = 4'b0110;
      for (int k = 1; k < int'(TO); k++) step();
      n_tests++;
      if (gnt !== 4'b0010 || timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL to_before gnt=%b terr=%b, required 0010/0", gnt, timeout_err);
      end
      step();
      n_tests++;
      if (gnt !== 4'b0000 || timeout_err !== 1'b1) begin
         n_fail++;
         $display("FAIL to_revoke gnt=%b terr=%b, required 0000/1", gnt, timeout_err);
      end
      step();
      n_tests++;
      if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL to_next_grant gnt=%b idx=%0d terr=%b, required 0100/2/0",
                  gnt, gnt_idx, timeout_err);
      end
   endtask

   task automatic test_done_at_timeout();
      req = 4'b0000;
      for (int k = 1; k < int'(TO); k++) step();
      done = 1'b1;
      step();
      done = 1'b0;
      n_tests++;
      if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL done_vs_timeout gnt=%b vld=%b terr=%b, required 0000/0/0",
                  gnt, gnt_vld, timeout_err);
      end
      step();
      n_tests++;
      if (timeout_err !== 1'b0 || gnt_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL done_vs_timeout_after terr=%b vld=%b, required 0/0", timeout_err, gnt_vld);
      end
   endtask

   task automatic test_async_reset();
      req = 4'b1000;
      step();
      step();
      n_tests++;
      if (gnt !== 4'b1000) begin
         n_fail++;
         $display("FAIL ar_busy gnt=%b, required 1000", gnt);
      end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_tests++;
      if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || timeout_err !== 1'b0 || gnt_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL ar_async_drop gnt=%b vld=%b terr=%b idx=%0d, required 0000/0/0/0",
                  gnt, gnt_vld, timeout_err, gnt_idx);
      end
      #2 rst_n = 1'b1;
      step();
      n_tests++;
      if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
         n_fail++;
         $display("FAIL ar_regrant gnt=%b idx=%0d, required 1000/3", gnt, gnt_idx);
      end
   endtask

   task automatic test_done_idle();
      req  = 4'b0000;
      done = 1'b1;
      step();
      for (int k = 0; k < 3; k++) begin
         step();
         n_tests++;
         if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || timeout_err !== 1'b0 || gnt_idx !== 2'd3) begin
            n_fail++;
            $display("FAIL done_idle[%0d] gnt=%b vld=%b terr=%b idx=%0d, required 0000/0/0/3",
                     k, gnt, gnt_vld, timeout_err, gnt_idx);
         end
      end
      done = 1'b0;
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int c = 0; c < 3000; c++) begin
         req  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) req = 4'b0000;
         done = ($urandom_range(0, 7) == 0);
         step();
         n_tests++;
         if (gnt !== exp_gnt() || gnt_vld !== m_vld || busy !== m_vld ||
             gnt_idx !== 2'(m_idx) || timeout_err !== m_terr) begin
            n_fail++;
            errs++;
            if (errs <= 10)
               $display("FAIL random[%0d] gnt=%b idx=%0d vld=%b terr=%b, required %b/%0d/%b/%b",
                        c, gnt, gnt_idx, gnt_vld, timeout_err, exp_gnt(), m_idx, m_vld, m_terr);
         end
         n_tests++;
         if ((gnt_vld && $countones(gnt) != 1) || (!gnt_vld && gnt != 4'b0000)) begin
            n_fail++;
            $display("FAIL onehot[%0d] gnt=%b vld=%b, required one-hot/zero", c, gnt, gnt_vld);
         end
      end
      done = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      req     = 4'b0000;
      done    = 1'b0;
      model_reset();
      #12;
      test_reset();
      rst_n = 1'b1;
      test_rr_order();
      test_single_hold();
      test_timeout();
      test_done_at_timeout();
      test_async_reset();
      test_done_idle();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
